// File: rtl/seg7_serial_drv_pkg.sv
// Shared types and constants for the serial 7-segment driver.
// Segment codes are active-high {g,f,e,d,c,b,a}.
package seg7_serial_drv_pkg;

    localparam int FRAME_W = 64;
    localparam int DIGITS  = 8;
    localparam int BCNT_W  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Board chain is active-low; a blanked digit also drops its point.
    function automatic logic [7:0] seg_byte(
        input logic [6:0] seg,
        input logic       dp,
        input logic       blank
    );
        return blank ? 8'hFF : ~{dp, seg};
    endfunction

endpackage

// File: rtl/seg7_serial_drv_hex_decode.sv
// Combinational hex nibble to active-high 7-segment code.
module seg7_hex_decode
    import seg7_serial_drv_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_serial_drv.sv
// Serialises eight 7-segment digit bytes into the board shift-register
// chain, with periodic refresh and on-demand update.
module seg7_serial_drv
    import seg7_serial_drv_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int REFRESH    = 4096,
    parameter int BLINK_BITS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic [7:0]  le,
    input  logic [7:0]  point,
    input  logic        update,
    output logic        seg_clk,
    output logic        seg_dout,
    output logic        seg_pen,
    output logic        seg_clrn,
    output logic        busy,
    output logic        frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int REF_W = $clog2(REFRESH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(FRAME_W - 1);

    state_t               state;
    state_t               state_n;
    logic [DIV_W-1:0]     div_cnt;
    logic [BCNT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]   shreg;
    logic [FRAME_W-1:0]   frame_next;
    logic [REF_W-1:0]     ref_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                 start_req;
    logic                 ref_tc;
    logic                 div_last;
    logic                 blink_ph;
    logic [6:0]           dec [DIGITS];

    assign ref_tc   = (ref_cnt == REF_LAST);
    assign div_last = (div_cnt == DIV_LAST);
    assign blink_ph = blink_cnt[BLINK_BITS-1];

    // Digit 7 lands in the top byte so it leaves the chain first.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        seg7_hex_decode u_dec (
            .nibble (disp_num[4*i +: 4]),
            .seg    (dec[i])
        );
        assign frame_next[8*i +: 8] =
            seg_byte(dec[i], point[i], le[i] & blink_ph);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start_req) state_n = LOAD;
            LOAD:  state_n = SHIFT;
            SHIFT: begin
                if (div_last && seg_clk && bit_cnt == BIT_LAST)
                    state_n = LATCH;
            end
            LATCH: if (div_last) state_n = DONE;
            DONE:  state_n = start_req ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt   <= '0;
            blink_cnt <= '0;
            start_req <= 1'b0;
            seg_clrn  <= 1'b0;
        end else begin
            seg_clrn  <= 1'b1;
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
            ref_cnt   <= ref_tc ? '0 : ref_cnt + REF_W'(1);
            // A fresh request wins over the clear so none is lost.
            if (update || ref_tc)
                start_req <= 1'b1;
            else if (state_n == LOAD)
                start_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            seg_clk <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    shreg   <= frame_next;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    seg_clk <= 1'b0;
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        seg_clk <= ~seg_clk;
                        if (seg_clk) begin
                            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + BCNT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LATCH: begin
                    div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign seg_dout   = shreg[FRAME_W-1];
    assign seg_pen    = (state == LATCH);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule
